// File: rtl/rng_conditioner_pkg.sv
// Shared types, defaults and the Von Neumann pair decode for the RNG conditioner.
package rng_conditioner_pkg;

  localparam int NUM_OF_RO      = 8;
  localparam int DEF_WORD_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_REP_LIMIT  = 32;

  typedef enum logic {VN_FIRST, VN_SECOND} vn_state_t;

  typedef struct packed {
    logic valid;
    logic value;
  } cbit_t;

  // 0,1 -> 0 and 1,0 -> 1, so the emitted bit is simply the first of an unequal pair.
  function automatic cbit_t vn_extract(input logic first, input logic second);
    cbit_t r;
    r.valid = first ^ second;
    r.value = first;
    return r;
  endfunction

endpackage

// File: rtl/rng_conditioner_if.sv
// Ready/valid word stream carrying conditioned output to the consumer.
interface rng_conditioner_if
  import rng_conditioner_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
);
  logic [WORD_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (output data_out, data_valid, input data_ready);
  modport slave  (input data_out, data_valid, output data_ready);
endinterface

// File: rtl/rng_conditioner_sync_fifo.sv
// Single-clock word FIFO with async reset and a synchronous flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two; level saturates by construction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/rng_conditioner.sv
// Von Neumann debiaser, LSB-first word packer and repetition-count health test feeding a word FIFO.
module rng_conditioner
  import rng_conditioner_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              raw_bit,
  rng_conditioner_if.master                 stream,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              health_fail
);
  localparam int BW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int RW = $clog2(REP_LIMIT+1);

  logic [1:0]            rst_sync;
  logic                  rst_int;
  vn_state_t             state;
  logic                  first_bit;
  logic [BW-1:0]         bit_cnt;
  logic [WORD_WIDTH-1:0] partial, push_word, fifo_head;
  logic [RW-1:0]         rep_cnt;
  logic                  last_bit;
  logic                  fifo_full, fifo_empty;
  logic                  trip, take, push, pop;
  cbit_t                 cb;

  // Assert immediately, release two edges after the external reset drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  assign trip = (rep_cnt == RW'(REP_LIMIT)) && !health_fail;
  assign cb   = vn_extract(first_bit, raw_bit);
  assign take = enable && !fifo_full && !health_fail && !trip &&
                (state == VN_SECOND) && cb.valid;
  assign push = take && (bit_cnt == BW'(WORD_WIDTH-1));
  assign pop  = stream.data_valid && stream.data_ready;

  assign stream.data_valid = !fifo_empty && !health_fail;
  assign stream.data_out   = fifo_head;

  always_comb begin
    push_word          = partial;
    push_word[bit_cnt] = cb.value;
  end

  // Full is the pre-pop level, so a cycle that drains the last slot still ignores raw_bit.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      state     <= VN_FIRST;
      first_bit <= 1'b0;
      bit_cnt   <= '0;
      partial   <= '0;
    end else if (trip || health_fail) begin
      state   <= VN_FIRST;
      bit_cnt <= '0;
      partial <= '0;
    end else if (!enable || fifo_full) begin
      state <= VN_FIRST;
    end else if (state == VN_FIRST) begin
      first_bit <= raw_bit;
      state     <= VN_SECOND;
    end else begin
      state <= VN_FIRST;
      if (cb.valid) begin
        if (push) begin
          bit_cnt <= '0;
          partial <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          partial <= push_word;
        end
      end
    end
  end

  // Runs on every enabled sample, independent of FIFO backpressure.
  always_ff @(posedge clock or posedge rst_int) begin
    if (rst_int) begin
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (trip) health_fail <= 1'b1;
      if (enable) begin
        last_bit <= raw_bit;
        if (rep_cnt == '0 || raw_bit != last_bit) rep_cnt <= RW'(1);
        else if (rep_cnt != RW'(REP_LIMIT))      rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (rst_int),
    .flush     (trip),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_rng_conditioner.sv
// Directed bench for rng_conditioner: vector table plus backpressure, reset and health sequences.
module tb_rng_conditioner;

  logic       clock = 1'b0;
  logic       reset, enable, raw_bit;
  logic [2:0] fifo_level;
  logic       health_fail;
  int         checks = 0;
  int         failures = 0;

  rng_conditioner_if #(.WORD_WIDTH(8)) sif();

  rng_conditioner dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .raw_bit     (raw_bit),
    .stream      (sif),
    .fifo_level  (fifo_level),
    .health_fail (health_fail)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] raw;
    int          len;
    int          pause_at;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample(input logic b);
    enable  = 1'b1;
    raw_bit = b;
    tick();
  endtask

  task automatic feed(input logic [31:0] raw, input int len);
    for (int k = 0; k < len; k++) sample(raw[len-1-k]);
  endtask

  task automatic pop_one();
    enable = 1'b0;
    sif.data_ready = 1'b1;
    tick();
    sif.data_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    logic [3:0] pat;
    logic [7:0] drain_exp [4];
    int words, first_at;

    // Raw streams are written in time order, first sample at the MSB of the len-bit field.
    vecs[0] = '{32'b0110_0110_0110_0110, 16, 8, 8'hAA};
    vecs[1] = '{32'b1010_1010_1010_1010, 16, 99, 8'hFF};
    vecs[2] = '{32'b0101_0101_0101_0101, 16, 99, 8'h00};
    vecs[3] = '{32'b00101110_00101110_00101110_00101110, 32, 99, 8'hFF};
    vecs[4] = '{32'b1001_0110_1010_0101, 16, 99, 8'h39};
    pat = 4'b0110;
    drain_exp[0] = 8'h39; drain_exp[1] = 8'hFF; drain_exp[2] = 8'h00; drain_exp[3] = 8'hAA;

    reset = 1'b0; enable = 1'b0; raw_bit = 1'b0; sif.data_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, sif.data_valid}, 0);
    chk("rst_data", {24'b0, sif.data_out}, 0);
    chk("rst_level", {29'b0, fifo_level}, 0);
    chk("rst_health", {31'b0, health_fail}, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < vecs[i].len; k++) begin
        if (k == vecs[i].pause_at) begin
          enable = 1'b0; raw_bit = 1'b1;
          repeat (3) tick();
          chk("pause_level", {29'b0, fifo_level}, 0);
        end
        sample(vecs[i].raw[vecs[i].len-1-k]);
      end
      chk("vec_valid", {31'b0, sif.data_valid}, 1);
      chk("vec_data", {24'b0, sif.data_out}, {24'b0, vecs[i].exp});
      chk("vec_level", {29'b0, fifo_level}, 1);
      pop_one();
      chk("vec_level_after_pop", {29'b0, fifo_level}, 0);
    end

    sif.data_ready = 1'b1;
    words = 0; first_at = -1;
    for (int k = 0; k < 64; k++) begin
      sample(pat[3 - (k % 4)]);
      if (sif.data_valid) begin
        chk("stream_word", {24'b0, sif.data_out}, 32'hAA);
        if (first_at < 0) first_at = k;
        words++;
      end
    end
    chk("stream_first_at", first_at, 15);
    chk("stream_words", words, 4);
    enable = 1'b0;
    tick();
    sif.data_ready = 1'b0;
    chk("stream_level_end", {29'b0, fifo_level}, 0);

    feed(vecs[4].raw, 16);
    feed(vecs[1].raw, 16);
    feed(vecs[2].raw, 16);
    feed(vecs[0].raw, 16);
    chk("bp_level_full", {29'b0, fifo_level}, 4);
    feed(vecs[0].raw, 16);
    chk("bp_level_sat", {29'b0, fifo_level}, 4);
    chk("bp_head_stable", {24'b0, sif.data_out}, 32'h39);
    enable = 1'b0;
    sif.data_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("drain_data", {24'b0, sif.data_out}, {24'b0, drain_exp[j]});
      chk("drain_level", {29'b0, fifo_level}, 4 - j);
      tick();
    end
    sif.data_ready = 1'b0;
    chk("drain_valid_end", {31'b0, sif.data_valid}, 0);
    feed(vecs[2].raw, 16);
    chk("post_full_word", {24'b0, sif.data_out}, 32'h00);
    chk("post_full_level", {29'b0, fifo_level}, 1);
    pop_one();

    feed(vecs[0].raw, 16);
    feed(vecs[1].raw, 16);
    feed(32'b1010_1010, 8);
    chk("mid_level", {29'b0, fifo_level}, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, sif.data_valid}, 0);
    chk("async_data", {24'b0, sif.data_out}, 0);
    chk("async_level", {29'b0, fifo_level}, 0);
    chk("async_health", {31'b0, health_fail}, 0);
    repeat (2) tick();
    reset = 1'b0; enable = 1'b0;
    repeat (3) tick();
    feed(vecs[2].raw, 16);
    chk("post_rst_word", {24'b0, sif.data_out}, 32'h00);
    chk("post_rst_level", {29'b0, fifo_level}, 1);
    pop_one();

    sample(1'b0);
    repeat (31) sample(1'b1);
    sample(1'b0); sample(1'b1); sample(1'b0); sample(1'b1);
    enable = 1'b0;
    repeat (2) tick();
    chk("rep31_no_fail", {31'b0, health_fail}, 0);

    do_reset();
    feed(vecs[0].raw, 16);
    chk("hf_pre_level", {29'b0, fifo_level}, 1);
    repeat (32) sample(1'b1);
    chk("hf_not_early", {31'b0, health_fail}, 0);
    chk("hf_level_before", {29'b0, fifo_level}, 1);
    enable = 1'b0;
    tick();
    chk("hf_set", {31'b0, health_fail}, 1);
    chk("hf_flush_level", {29'b0, fifo_level}, 0);
    chk("hf_valid", {31'b0, sif.data_valid}, 0);
    feed(vecs[0].raw, 16);
    chk("hf_no_write_level", {29'b0, fifo_level}, 0);
    chk("hf_no_write_valid", {31'b0, sif.data_valid}, 0);
    chk("hf_sticky", {31'b0, health_fail}, 1);
    enable = 1'b0;
    reset = 1'b1;
    #1;
    chk("hf_cleared_by_rst", {31'b0, health_fail}, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
